spi_pixel_receiver: RTL and testbench

- Next-generation SPI pixel input for the HUB75 controller. Replaces direct spi_clk clocking with a single system-clock design: SPI pins are oversampled and synchronised.
- Accepts mode-0, MSB-first words of CHANNELS bytes framed by chip-select.
- Truncates each byte to BITS_PER_CHANNEL MSBs and presents the packed pixel on a valid/ready interface to the frame-buffer writer.
- Adds framing, backpressure, a one-entry holding register and overrun detection.

---
 rtl/hub75_pkg.sv | 24 ++
 rtl/spi_pixel_receiver_if.sv | 24 ++
 rtl/spi_input_sync.sv | 32 +++
 rtl/spi_pixel_receiver.sv | 151 +++++++++++++++
 tb/tb_spi_pixel_receiver.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hub75_pkg.sv
// Shared HUB75 constants and width helpers used by the SPI pixel receiver
// and the frame-buffer writer.
package hub75_pkg;

  localparam int SPI_BYTE_BITS       = 8;
  localparam int DEFAULT_SYNC_STAGES = 2;

  // Word and pixel widths derived from the channel configuration.
  typedef struct packed {
    logic [15:0] word_bits;
    logic [15:0] pixel_bits;
  } hub75_widths_t;

  // Both widths come from one place so the SPI side and the frame-buffer
  // side can never disagree about the packed pixel size.
  function automatic hub75_widths_t hub75_widths(input int channels,
                                                 input int bits_per_channel);
    hub75_widths_t w;
    w.word_bits  = 16'(SPI_BYTE_BITS * channels);
    w.pixel_bits = 16'(channels * bits_per_channel);
    return w;
  endfunction

endpackage

// File: rtl/spi_pixel_receiver_if.sv
// Valid/ready pixel stream between the SPI receiver and the frame-buffer writer.
interface spi_pixel_receiver_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] pixel_data;
  logic             pixel_valid;
  logic             pixel_ready;

  // The producer drives data/valid and observes ready.
  modport master (
    output pixel_data,
    output pixel_valid,
    input  pixel_ready
  );

  // The consumer observes data/valid and drives ready.
  modport slave (
    input  pixel_data,
    input  pixel_valid,
    output pixel_ready
  );

endinterface

// File: rtl/spi_input_sync.sv
// Single-bit multi-flop synchroniser for bringing raw SPI pins into clk.
module spi_input_sync
  import hub75_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // New sample enters at bit 0; the oldest stage is the synchronised output.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  // Synchroniser chain, cleared to 0 on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_pixel_receiver.sv
// Oversampling SPI (mode 0, MSB first) pixel receiver. Each chip-select framed
// word of CHANNELS bytes is truncated to BITS_PER_CHANNEL MSBs per byte and
// offered on a valid/ready stream through a one-entry holding register.
module spi_pixel_receiver
  import hub75_pkg::*;
#(
  parameter int CHANNELS         = 4,
  parameter int BITS_PER_CHANNEL = 4,
  parameter int SYNC_STAGES      = DEFAULT_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 spi_clk,
  input  logic                 spi_mosi,
  input  logic                 spi_cs_n,
  spi_pixel_receiver_if.master pix,
  output logic                 overrun,
  input  logic                 clear_overrun,
  output logic                 busy
);

  localparam hub75_widths_t WIDTHS = hub75_widths(CHANNELS, BITS_PER_CHANNEL);
  localparam int WORD_BITS  = int'(WIDTHS.word_bits);
  localparam int PIXEL_BITS = int'(WIDTHS.pixel_bits);
  localparam int CNT_W      = $clog2(WORD_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_BITS - 1);

  logic sclk_s;
  logic mosi_s;
  logic cs_s;

  logic                  sclk_prev_q, sclk_prev_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [WORD_BITS-2:0]  shift_q, shift_d;
  logic [PIXEL_BITS-1:0] pixel_data_q, pixel_data_d;
  logic                  pixel_valid_q, pixel_valid_d;
  logic                  overrun_q, overrun_d;

  logic                  rise;
  logic                  word_done;
  logic                  drop;
  logic [WORD_BITS-1:0]  next_word;
  logic [7:0]            byte_v;
  logic [PIXEL_BITS-1:0] packed_pixel;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (spi_clk),
    .q       (sclk_s)
  );

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (spi_mosi),
    .q       (mosi_s)
  );

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (spi_cs_n),
    .q       (cs_s)
  );

  assign rise      = sclk_s & ~sclk_prev_q;
  assign word_done = ~cs_s & rise & (bit_cnt_q == '0);
  // The completing word includes the bit arriving this cycle, so the pixel
  // can be loaded on the same edge that consumes the last bit.
  assign next_word = {shift_q, mosi_s};

  // Keep the top BITS_PER_CHANNEL bits of each byte; the first byte lands in
  // the most significant pixel field.
  always_comb begin
    packed_pixel = '0;
    byte_v       = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      byte_v = next_word[WORD_BITS-1-SPI_BYTE_BITS*c -: SPI_BYTE_BITS];
      packed_pixel[(CHANNELS-c)*BITS_PER_CHANNEL-1 -: BITS_PER_CHANNEL] =
        BITS_PER_CHANNEL'(byte_v >> (SPI_BYTE_BITS - BITS_PER_CHANNEL));
    end
  end

  // Bit framing: deselect parks the counter, each SPI rise shifts one bit.
  always_comb begin
    sclk_prev_d = sclk_s;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    if (cs_s) begin
      bit_cnt_d = CNT_LAST;
    end else if (rise) begin
      shift_d = next_word[WORD_BITS-2:0];
      if (bit_cnt_q == '0) begin
        bit_cnt_d = CNT_LAST;
      end else begin
        bit_cnt_d = bit_cnt_q - CNT_W'(1);
      end
    end
  end

  // Holding register: a finished word is accepted if the slot is free or is
  // being emptied this cycle, otherwise it is dropped and flagged.
  always_comb begin
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = pixel_valid_q;
    overrun_d     = overrun_q;
    drop          = 1'b0;
    if (word_done) begin
      if (!pixel_valid_q || pix.pixel_ready) begin
        pixel_data_d  = packed_pixel;
        pixel_valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (pixel_valid_q && pix.pixel_ready) begin
      pixel_valid_d = 1'b0;
    end
    if (clear_overrun) begin
      overrun_d = 1'b0;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end
  end

  // All receiver state, returned to idle by the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_prev_q   <= 1'b0;
      bit_cnt_q     <= CNT_LAST;
      shift_q       <= '0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      sclk_prev_q   <= sclk_prev_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign pix.pixel_data  = pixel_data_q;
  assign pix.pixel_valid = pixel_valid_q;
  assign overrun         = overrun_q;
  assign busy            = ~cs_s & (bit_cnt_q != CNT_LAST);

endmodule

// File: tb/tb_spi_pixel_receiver.sv
// Self-checking bench: a default-configured receiver (4x4) and a 3x8 receiver
// are driven with directed SPI frames and compared every cycle to a
// transaction-level model, plus literal checks on the delivered pixels.
module tb_spi_pixel_receiver;

  typedef struct {
    int          due;
    logic [63:0] word;
  } ev_t;

  typedef struct {
    bit          v;
    logic [63:0] d;
    bit          o;
  } mstate_t;

  logic       clk;
  logic       reset_n;
  logic [1:0] sclk;
  logic [1:0] mosi;
  logic [1:0] csn;
  logic [1:0] ready;
  logic [1:0] clr;
  wire  [1:0] ovr_w;
  wire  [1:0] busy_w;

  int          total;
  int          bad;
  int          cyc;
  bit          cmp_en;
  ev_t         evq0[$];
  ev_t         evq1[$];
  mstate_t     m[2];
  int          bitcnt[2];
  logic [63:0] shacc[2];
  logic [63:0] acc0[$];
  logic [63:0] acc1[$];

  spi_pixel_receiver_if #(.WIDTH(16)) pix0 ();
  spi_pixel_receiver_if #(.WIDTH(24)) pix1 ();

  assign pix0.pixel_ready = ready[0];
  assign pix1.pixel_ready = ready[1];

  spi_pixel_receiver #(
    .CHANNELS(4), .BITS_PER_CHANNEL(4), .SYNC_STAGES(2)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .spi_clk(sclk[0]), .spi_mosi(mosi[0]),
    .spi_cs_n(csn[0]), .pix(pix0), .overrun(ovr_w[0]),
    .clear_overrun(clr[0]), .busy(busy_w[0])
  );

  spi_pixel_receiver #(
    .CHANNELS(3), .BITS_PER_CHANNEL(8), .SYNC_STAGES(2)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .spi_clk(sclk[1]), .spi_mosi(mosi[1]),
    .spi_cs_n(csn[1]), .pix(pix1), .overrun(ovr_w[1]),
    .clear_overrun(clr[1]), .busy(busy_w[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int ch_of(input int sel);
    return (sel == 0) ? 4 : 3;
  endfunction

  function automatic int bpc_of(input int sel);
    return (sel == 0) ? 4 : 8;
  endfunction

  function automatic int wb_of(input int sel);
    return 8 * ch_of(sel);
  endfunction

  // Pixel from a word: walk the bytes first-to-last, keep each byte's top bits.
  function automatic logic [63:0] model_pack(input logic [63:0] w, input int ch,
                                             input int bpc);
    logic [63:0] r;
    logic [63:0] b;
    r = 64'd0;
    for (int c = 0; c < ch; c++) begin
      b = (w >> (8 * (ch - 1 - c))) & 64'hFF;
      r = (r << bpc) | (b >> (8 - bpc));
    end
    return r;
  endfunction

  // One clock edge of the holding-register / overrun rules.
  function automatic mstate_t model_step(input mstate_t s, input bit comp,
                                         input logic [63:0] w, input int ch,
                                         input int bpc, input bit rdy,
                                         input bit clr_i);
    mstate_t n;
    bit      drop;
    n    = s;
    drop = 1'b0;
    if (comp) begin
      if (!s.v || rdy) begin
        n.d = model_pack(w, ch, bpc);
        n.v = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (s.v && rdy) begin
      n.v = 1'b0;
    end
    if (clr_i) n.o = 1'b0;
    if (drop)  n.o = 1'b1;
    return n;
  endfunction

  task automatic check_output(input string nm, input logic [63:0] act,
                              input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model update on every edge; words take effect at their scheduled edge.
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m[0] = '{1'b0, 64'd0, 1'b0};
        m[1] = '{1'b0, 64'd0, 1'b0};
        evq0.delete();
        evq1.delete();
      end else begin
        bit          c0;
        bit          c1;
        logic [63:0] w0;
        logic [63:0] w1;
        cyc++;
        c0 = 1'b0;
        c1 = 1'b0;
        w0 = 64'd0;
        w1 = 64'd0;
        if (evq0.size() > 0 && evq0[0].due == cyc) begin
          c0 = 1'b1;
          w0 = evq0.pop_front().word;
        end
        if (evq1.size() > 0 && evq1[0].due == cyc) begin
          c1 = 1'b1;
          w1 = evq1.pop_front().word;
        end
        m[0] = model_step(m[0], c0, w0, 4, 4, ready[0], clr[0]);
        m[1] = model_step(m[1], c1, w1, 3, 8, ready[1], clr[1]);
      end
    end
  end

  // Per-cycle comparison against the model and log of delivered pixels.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check_output("valid0", 64'(pix0.pixel_valid), 64'(m[0].v));
        check_output("data0", 64'(pix0.pixel_data), m[0].d);
        check_output("overrun0", 64'(ovr_w[0]), 64'(m[0].o));
        check_output("valid1", 64'(pix1.pixel_valid), 64'(m[1].v));
        check_output("data1", 64'(pix1.pixel_data), m[1].d);
        check_output("overrun1", 64'(ovr_w[1]), 64'(m[1].o));
        if (pix0.pixel_valid && ready[0]) acc0.push_back(64'(pix0.pixel_data));
        if (pix1.pixel_valid && ready[1]) acc1.push_back(64'(pix1.pixel_data));
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic cs_low(input int sel);
    csn[sel] = 1'b0;
    idle(4);
  endtask

  task automatic cs_high(input int sel);
    idle(4);
    csn[sel] = 1'b1;
    bitcnt[sel] = 0;
    idle(4);
  endtask

  // One SPI bit. pulse=1 raises ready, pulse=2 raises clear_overrun, exactly
  // on the edge at which this bit's word completes inside the receiver.
  task automatic spi_bit(input int sel, input bit b, input int pulse);
    int  n;
    ev_t ev;
    sclk[sel] = 1'b0;
    mosi[sel] = b;
    idle(4);
    sclk[sel] = 1'b1;
    n = cyc;
    if (bitcnt[sel] == 0) shacc[sel] = 64'd0;
    shacc[sel] = (shacc[sel] << 1) | 64'(b);
    bitcnt[sel]++;
    if (bitcnt[sel] == wb_of(sel)) begin
      ev.due  = n + 3;
      ev.word = shacc[sel];
      if (sel == 0) evq0.push_back(ev);
      else          evq1.push_back(ev);
      bitcnt[sel] = 0;
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 2) begin
        if (pulse == 1) ready[sel] = 1'b1;
        if (pulse == 2) clr[sel] = 1'b1;
      end else if (i == 3) begin
        if (pulse == 1) ready[sel] = 1'b0;
        if (pulse == 2) check_output("overrun_set_dominant", 64'(ovr_w[sel]), 64'd1);
      end else if (i == 4) begin
        if (pulse == 2) begin
          check_output("overrun_cleared", 64'(ovr_w[sel]), 64'd0);
          clr[sel] = 1'b0;
        end
      end
    end
    sclk[sel] = 1'b0;
  endtask

  task automatic send_bits(input int sel, input logic [63:0] w, input int n,
                           input int pulse);
    for (int i = 0; i < n; i++) begin
      spi_bit(sel, w[wb_of(sel) - 1 - i], (i == n - 1) ? pulse : 0);
    end
  endtask

  task automatic send_word(input int sel, input logic [63:0] w, input int pulse);
    send_bits(sel, w, wb_of(sel), pulse);
  endtask

  task automatic check_reset_outputs(input int sel);
    if (sel == 0) begin
      check_output("rst_valid0", 64'(pix0.pixel_valid), 64'd0);
      check_output("rst_data0", 64'(pix0.pixel_data), 64'd0);
    end else begin
      check_output("rst_valid1", 64'(pix1.pixel_valid), 64'd0);
      check_output("rst_data1", 64'(pix1.pixel_data), 64'd0);
    end
    check_output("rst_overrun", 64'(ovr_w[sel]), 64'd0);
    check_output("rst_busy", 64'(busy_w[sel]), 64'd0);
  endtask

  // Directed scenarios.
  initial begin
    total   = 0;
    bad     = 0;
    cmp_en  = 1'b0;
    reset_n = 1'b0;
    sclk    = 2'b00;
    mosi    = 2'b00;
    csn     = 2'b11;
    ready   = 2'b00;
    clr     = 2'b00;
    bitcnt[0] = 0;
    bitcnt[1] = 0;
    shacc[0]  = 64'd0;
    shacc[1]  = 64'd0;

    idle(3);
    check_reset_outputs(0);
    check_reset_outputs(1);
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    idle(5);

    check_output("pack_fabc", model_pack(64'hF1A2B3C4, 4, 4), 64'hFABC);
    check_output("pack_1357", model_pack(64'h12345678, 4, 4), 64'h1357);
    check_output("pack_9bdf", model_pack(64'h9ABCDEF0, 4, 4), 64'h9BDF);
    check_output("pack_112233", model_pack(64'h112233, 3, 8), 64'h112233);

    // Single word with the consumer always ready.
    ready[0] = 1'b1;
    cs_low(0);
    send_word(0, 64'hF1A2B3C4, 0);
    cs_high(0);
    check_output("t1_count", 64'(acc0.size()), 64'd1);
    check_output("t1_pixel", (acc0.size() > 0) ? acc0[0] : 64'hDEAD, 64'hFABC);
    check_output("t1_overrun", 64'(ovr_w[0]), 64'd0);
    check_output("t1_busy", 64'(busy_w[0]), 64'd0);

    // Two words against a stalled consumer: the second one is dropped.
    acc0.delete();
    ready[0] = 1'b0;
    cs_low(0);
    send_word(0, 64'h12345678, 0);
    send_word(0, 64'h9ABCDEF0, 0);
    cs_high(0);
    check_output("t2_held", 64'(pix0.pixel_data), 64'h1357);
    check_output("t2_overrun", 64'(ovr_w[0]), 64'd1);
    ready[0] = 1'b1;
    idle(4);
    check_output("t2_count", 64'(acc0.size()), 64'd1);
    check_output("t2_pixel", (acc0.size() > 0) ? acc0[0] : 64'hDEAD, 64'h1357);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    step();
    check_output("t2_clear", 64'(ovr_w[0]), 64'd0);

    // Partial word discarded by deselect, then a clean word.
    acc0.delete();
    cs_low(0);
    send_bits(0, 64'hFFFFFFFF, 13, 0);
    idle(2);
    check_output("t3_busy_partial", 64'(busy_w[0]), 64'd1);
    cs_high(0);
    check_output("t3_busy_released", 64'(busy_w[0]), 64'd0);
    cs_low(0);
    send_word(0, 64'h12345678, 0);
    cs_high(0);
    check_output("t3_count", 64'(acc0.size()), 64'd1);
    check_output("t3_pixel", (acc0.size() > 0) ? acc0[0] : 64'hDEAD, 64'h1357);

    // Consumer accepts in the very cycle the next word completes.
    acc0.delete();
    ready[0] = 1'b0;
    cs_low(0);
    send_word(0, 64'h11223344, 0);
    send_word(0, 64'h55667788, 1);
    check_output("t4_count", 64'(acc0.size()), 64'd1);
    check_output("t4_old", (acc0.size() > 0) ? acc0[0] : 64'hDEAD, 64'h1234);
    check_output("t4_new", 64'(pix0.pixel_data), 64'h5678);
    check_output("t4_valid", 64'(pix0.pixel_valid), 64'd1);
    check_output("t4_overrun", 64'(ovr_w[0]), 64'd0);

    // Drop, then a drop coinciding with clear_overrun, then clear alone.
    send_word(0, 64'h99AABBCC, 0);
    check_output("t5_overrun", 64'(ovr_w[0]), 64'd1);
    send_word(0, 64'hDDEEFF00, 2);
    cs_high(0);
    ready[0] = 1'b1;
    idle(4);
    check_output("t5_count", 64'(acc0.size()), 64'd2);
    check_output("t5_pixel", (acc0.size() > 1) ? acc0[1] : 64'hDEAD, 64'h5678);
    ready[0] = 1'b0;

    // 3x8 receiver: full-width pixel, then reset while busy with a pixel held.
    ready[1] = 1'b0;
    cs_low(1);
    send_word(1, 64'h112233, 0);
    cs_high(1);
    check_output("t6_pixel", 64'(pix1.pixel_data), 64'h112233);
    check_output("t6_valid", 64'(pix1.pixel_valid), 64'd1);
    cs_low(1);
    send_bits(1, 64'hA5C3E7, 10, 0);
    idle(2);
    check_output("t6_busy", 64'(busy_w[1]), 64'd1);
    reset_n = 1'b0;
    step();
    check_reset_outputs(1);
    check_reset_outputs(0);
    csn[1] = 1'b1;
    bitcnt[0] = 0;
    bitcnt[1] = 0;
    step();
    reset_n = 1'b1;
    idle(6);
    acc1.delete();
    ready[1] = 1'b1;
    cs_low(1);
    send_word(1, 64'hA5C3E7, 0);
    cs_high(1);
    check_output("t6_count", 64'(acc1.size()), 64'd1);
    check_output("t6_after_reset", (acc1.size() > 0) ? acc1[0] : 64'hDEAD, 64'hA5C3E7);
    check_output("t6_overrun", 64'(ovr_w[1]), 64'd0);

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
